// File: rtl/seven_segment_reader.sv
// Captures four strobed active-low seven-segment digits into a 16-bit hex frame
// and offers it to a consumer over a valid/ready handshake.
module seven_segment_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        in_clock,
    input  logic        in_reset_n,
    input  logic [6:0]  in_seven_segment,
    input  logic        in_digit_strobe,
    input  logic        in_ready,
    output logic [15:0] out_value,
    output logic [3:0]  out_error_mask,
    output logic        out_valid,
    output logic        out_timeout,
    output logic        out_overrun
);

    // Handshake: a frame transfers on every rising edge where out_valid and
    // in_ready are both high; out_valid never drops before that edge and
    // out_value/out_error_mask stay frozen while it is high.
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  counter, counter_n;
    logic [15:0] timer, timer_n;
    logic [15:0] value_n;
    logic [3:0]  mask_n;
    logic        valid_n, timeout_n, overrun_n;
    logic [4:0]  dec;

    // Returns {error, nibble}; unrecognised patterns give nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0011000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b0100111: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    assign dec = decode(in_seven_segment);

    always_comb begin
        state_n   = state;
        counter_n = counter;
        timer_n   = timer;
        value_n   = out_value;
        mask_n    = out_error_mask;
        valid_n   = out_valid;
        timeout_n = 1'b0;
        overrun_n = 1'b0;
        case (state)
            IDLE: begin
                if (in_digit_strobe) begin
                    value_n   = {12'h000, dec[3:0]};
                    mask_n    = {3'b000, dec[4]};
                    counter_n = 2'd1;
                    timer_n   = 16'h0000;
                    state_n   = COLLECT;
                end
            end
            COLLECT: begin
                if (in_digit_strobe) begin
                    value_n[{counter, 2'b00} +: 4] = dec[3:0];
                    mask_n[counter]                = dec[4];
                    timer_n                        = 16'h0000;
                    counter_n                      = counter + 2'd1;
                    if (counter == 2'd3) begin
                        state_n = HOLD;
                        valid_n = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    // Abort: the partial frame is thrown away.
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                    counter_n = 2'd0;
                    timer_n   = 16'h0000;
                    value_n   = 16'h0000;
                    mask_n    = 4'b0000;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            HOLD: begin
                overrun_n = in_digit_strobe;
                if (in_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state          <= IDLE;
            counter        <= 2'd0;
            timer          <= 16'h0000;
            out_value      <= 16'h0000;
            out_error_mask <= 4'b0000;
            out_valid      <= 1'b0;
            out_timeout    <= 1'b0;
            out_overrun    <= 1'b0;
        end else begin
            state          <= state_n;
            counter        <= counter_n;
            timer          <= timer_n;
            out_value      <= value_n;
            out_error_mask <= mask_n;
            out_valid      <= valid_n;
            out_timeout    <= timeout_n;
            out_overrun    <= overrun_n;
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: frames are predicted from a reference segment
// table, queued when driven and compared when the handshake fires.
module tb_seven_segment_reader;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic        strobe;
    logic        ready;
    logic [15:0] out_value;
    logic [3:0]  out_mask;
    logic        out_valid;
    logic        out_timeout;
    logic        out_overrun;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_q[$];
    logic [6:0]  seg_tab [16];
    logic [6:0]  pats [24];

    seven_segment_reader #(.TIMEOUT_CYCLES(T)) dut (
        .in_clock         (clk),
        .in_reset_n       (rst_n),
        .in_seven_segment (seg),
        .in_digit_strobe  (strobe),
        .in_ready         (ready),
        .out_value        (out_value),
        .out_error_mask   (out_mask),
        .out_valid        (out_valid),
        .out_timeout      (out_timeout),
        .out_overrun      (out_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] model(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    task automatic strobe_digit(input logic [6:0] p);
        seg    = p;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        seg    = 7'h7f;
    endtask

    task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3);
        logic [6:0]  p [4];
        logic [15:0] v;
        logic [3:0]  m;
        logic [4:0]  d;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        v = '0;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            d = model(p[k]);
            v[k*4 +: 4] = d[3:0];
            m[k]        = d[4];
        end
        exp_q.push_back({m, v});
        for (int k = 0; k < 4; k++) strobe_digit(p[k]);
    endtask

    // Scoreboard: a frame leaves on any edge where valid and ready are both high.
    always @(negedge clk) begin
        logic [19:0] e;
        if (rst_n && out_valid && ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("frame_value", 32'(out_value), 32'(e[15:0]));
                check_eq("frame_mask", 32'(out_mask), 32'(e[19:16]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] r;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < 16; i++) pats[i] = seg_tab[i];
        for (int i = 16; i < 24; i++) begin
            r = 7'($urandom_range(0, 127));
            while (!model(r)[4]) r = 7'($urandom_range(0, 127));
            pats[i] = r;
        end

        // Clock/reset
        rst_n  = 1'b0;
        seg    = 7'h7f;
        strobe = 1'b0;
        ready  = 1'b0;
        #12;
        check_eq("rst_value", 32'(out_value), 32'h0);
        check_eq("rst_mask", 32'(out_mask), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_timeout", 32'(out_timeout), 32'h0);
        check_eq("rst_overrun", 32'(out_overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4,3,2,1 with ready high: valid one cycle after the 4th strobe, then gone.
        ready = 1'b1;
        send_frame(seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]);
        check_eq("lat_valid", 32'(out_valid), 32'h1);
        check_eq("lat_value", 32'(out_value), 32'h1234);
        @(posedge clk);
        #1;
        check_eq("valid_drop", 32'(out_valid), 32'h0);

        // F,0,blank,A held for 10 cycles with ready low.
        ready = 1'b0;
        send_frame(seg_tab[15], seg_tab[0], 7'h7f, seg_tab[10]);
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_valid", 32'(out_valid), 32'h1);
            check_eq("hold_value", 32'(out_value), 32'hA00F);
            check_eq("hold_mask", 32'(out_mask), 32'h4);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check_eq("hs_valid", 32'(out_valid), 32'h0);
        check_eq("retain_value", 32'(out_value), 32'hA00F);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_idle", 32'(out_valid), 32'h0);

        // Two strobes, then silence: timeout exactly on the T-th idle edge.
        strobe_digit(seg_tab[9]);
        strobe_digit(seg_tab[9]);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("timeout_pulse", 32'(out_timeout), 32'(i == int'(T)));
            check_eq("timeout_novalid", 32'(out_valid), 32'h0);
        end
        send_frame(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8]);
        check_eq("after_to_value", 32'(out_value), 32'h8765);
        @(posedge clk);
        #1;

        // Strobes in HOLD are dropped, also on the handshake edge.
        ready = 1'b0;
        send_frame(seg_tab[1], seg_tab[1], seg_tab[1], seg_tab[1]);
        strobe_digit(seg_tab[9]);
        check_eq("ovr_hold", 32'(out_overrun), 32'h1);
        check_eq("ovr_hold_valid", 32'(out_valid), 32'h1);
        check_eq("ovr_hold_value", 32'(out_value), 32'h1111);
        seg    = seg_tab[9];
        strobe = 1'b1;
        ready  = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        check_eq("ovr_hs", 32'(out_overrun), 32'h1);
        check_eq("ovr_hs_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check_eq("ovr_clear", 32'(out_overrun), 32'h0);
        send_frame(seg_tab[3], seg_tab[4], seg_tab[5], seg_tab[6]);
        check_eq("post_ovr_value", 32'(out_value), 32'h6543);
        @(posedge clk);
        #1;

        // Asynchronous reset after three strobes.
        strobe_digit(seg_tab[7]);
        strobe_digit(seg_tab[7]);
        strobe_digit(seg_tab[7]);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_value", 32'(out_value), 32'h0);
        check_eq("arst_mask", 32'(out_mask), 32'h0);
        check_eq("arst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(seg_tab[12], seg_tab[13], seg_tab[14], seg_tab[11]);
        check_eq("post_rst_value", 32'(out_value), 32'hBEDC);
        @(posedge clk);
        #1;

        // Every pattern through every digit position.
        for (int f = 0; f < 24; f++) begin
            send_frame(pats[f % 24], pats[(f + 5) % 24], pats[(f + 11) % 24], pats[(f + 17) % 24]);
            @(posedge clk);
            #1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        check_eq("sb_left", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
